// File: rtl/cplx_mac_seq_if.sv
// Sample/replica input, shared-multiplier handshake and dump output of cplx_mac_seq.
interface cplx_mac_seq_if #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [15:0]      x_re;
  logic signed [15:0]      x_im;
  logic signed [15:0]      c_re;
  logic signed [15:0]      c_im;
  logic [CNT_W-1:0]        dump_len;
  logic signed [15:0]      mult_a;
  logic signed [15:0]      mult_b;
  logic                    mult_start;
  logic                    mult_busy;
  logic signed [31:0]      mult_p;
  logic                    out_valid;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;

  modport slave (
    input  in_valid, x_re, x_im, c_re, c_im, dump_len, mult_busy, mult_p,
    output in_ready, mult_a, mult_b, mult_start, out_valid, acc_i, acc_q
  );

  modport master (
    output in_valid, x_re, x_im, c_re, c_im, dump_len, mult_busy, mult_p,
    input  in_ready, mult_a, mult_b, mult_start, out_valid, acc_i, acc_q
  );
endinterface

// File: rtl/cplx_mac_seq.sv
// Complex MAC sequencer: four real multiplies per sample on one shared multiplier,
// windowed I/Q accumulation and a one-cycle dump strobe at the end of each window.
module cplx_mac_seq #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  cplx_mac_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DUMP    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]        CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  // Operand pair {a, b} of multiply k: xr*cr, xi*ci, xr*ci, xi*cr.
  function automatic logic [31:0] op_pair(input logic [1:0] k, input logic [15:0] xr,
                                          input logic [15:0] xi, input logic [15:0] cr,
                                          input logic [15:0] ci);
    logic [31:0] pair;
    case (k)
      2'd0:    pair = {xr, cr};
      2'd1:    pair = {xi, ci};
      2'd2:    pair = {xr, ci};
      2'd3:    pair = {xi, cr};
      default: pair = {xr, cr};
    endcase
    return pair;
  endfunction

  state_t                  state_r, state_s;
  logic [1:0]              k_r;
  logic signed [15:0]      xr_r, xi_r, cr_r, ci_r;
  logic [CNT_W-1:0]        len_r, cnt_r;
  logic signed [ACC_W-1:0] sum_i_r, sum_q_r;
  logic                    in_ready_r, mult_start_r, out_valid_r;
  logic signed [15:0]      mult_a_r, mult_b_r;
  logic signed [ACC_W-1:0] acc_i_r, acc_q_r;

  logic                    accept_s, capture_s, last_mul_s, win_done_s;
  logic                    in_ready_s, mult_start_s, out_valid_s;
  logic [31:0]             ops_s;
  logic signed [ACC_W-1:0] prod_ext_s;

  assign accept_s   = (state_r == ST_IDLE) && bus.in_valid && in_ready_r;
  assign capture_s  = (state_r == ST_WAIT_LO) && !bus.mult_busy;
  assign last_mul_s = (k_r == 2'd3);
  assign win_done_s = ((cnt_r + CNT_ONE) == len_r);
  assign prod_ext_s = {{(ACC_W-32){bus.mult_p[31]}}, bus.mult_p};

  assign bus.in_ready   = in_ready_r;
  assign bus.mult_start = mult_start_r;
  assign bus.mult_a     = mult_a_r;
  assign bus.mult_b     = mult_b_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.acc_i      = acc_i_r;
  assign bus.acc_q      = acc_q_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_START;
        else          state_s = ST_IDLE;
      end
      ST_START: state_s = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (bus.mult_busy) state_s = ST_WAIT_LO;
        else               state_s = ST_WAIT_HI;
      end
      ST_WAIT_LO: begin
        if (bus.mult_busy)   state_s = ST_WAIT_LO;
        else if (last_mul_s) state_s = ST_NEXT;
        else                 state_s = ST_START;
      end
      ST_NEXT: begin
        if (win_done_s) state_s = ST_DUMP;
        else            state_s = ST_IDLE;
      end
      ST_DUMP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so each output is a flop that is valid in its state.
  always_comb begin
    in_ready_s   = (state_s == ST_IDLE);
    mult_start_s = (state_s == ST_START);
    out_valid_s  = (state_s == ST_DUMP);
    ops_s        = {mult_a_r, mult_b_r};
    if (accept_s) begin
      ops_s = op_pair(2'd0, bus.x_re, bus.x_im, bus.c_re, bus.c_im);
    end else if (capture_s && !last_mul_s) begin
      ops_s = op_pair(k_r + 2'd1, xr_r, xi_r, cr_r, ci_r);
    end else begin
      ops_s = {mult_a_r, mult_b_r};
    end
  end

  // Output registers; operands only change on entry to START, so they hold through capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r   <= 1'b0;
      mult_start_r <= 1'b0;
      out_valid_r  <= 1'b0;
      mult_a_r     <= 16'sd0;
      mult_b_r     <= 16'sd0;
      acc_i_r      <= ACC_ZERO;
      acc_q_r      <= ACC_ZERO;
    end else begin
      in_ready_r   <= in_ready_s;
      mult_start_r <= mult_start_s;
      out_valid_r  <= out_valid_s;
      mult_a_r     <= ops_s[31:16];
      mult_b_r     <= ops_s[15:0];
      if (state_s == ST_DUMP) begin
        acc_i_r <= sum_i_r;
        acc_q_r <= sum_q_r;
      end
    end
  end

  // Sample latch, multiply index, window counter and wrapping accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr_r    <= 16'sd0;
      xi_r    <= 16'sd0;
      cr_r    <= 16'sd0;
      ci_r    <= 16'sd0;
      k_r     <= 2'd0;
      len_r   <= CNT_ONE;
      cnt_r   <= CNT_ZERO;
      sum_i_r <= ACC_ZERO;
      sum_q_r <= ACC_ZERO;
    end else if (accept_s) begin
      xr_r <= bus.x_re;
      xi_r <= bus.x_im;
      cr_r <= bus.c_re;
      ci_r <= bus.c_im;
      k_r  <= 2'd0;
      if (cnt_r == CNT_ZERO) begin
        len_r <= (bus.dump_len == CNT_ZERO) ? CNT_ONE : bus.dump_len;
      end
    end else if (capture_s) begin
      k_r <= k_r + 2'd1;
      case (k_r)
        2'd0:       sum_i_r <= sum_i_r + prod_ext_s;
        2'd1:       sum_i_r <= sum_i_r - prod_ext_s;
        2'd2, 2'd3: sum_q_r <= sum_q_r + prod_ext_s;
        default:    sum_q_r <= sum_q_r;
      endcase
    end else if (state_r == ST_NEXT) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else if (state_r == ST_DUMP) begin
      cnt_r   <= CNT_ZERO;
      sum_i_r <= ACC_ZERO;
      sum_q_r <= ACC_ZERO;
    end
  end

endmodule

// File: tb/tb_cplx_mac_seq.sv
// Bench for cplx_mac_seq: behavioural multiplier with random latency, and a window-sum
// reference model built from the complex-product definition.
module tb_cplx_mac_seq;
  localparam int ACC_W = 48;
  localparam int CNT_W = 16;

  typedef struct {
    logic signed [ACC_W-1:0] i;
    logic signed [ACC_W-1:0] q;
    int                      at;
  } dump_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cplx_mac_seq_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
  cplx_mac_seq #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int n_dumps = 0;
  int n_starts = 0;
  int n_accepted = 0;
  int cfg_bmin, cfg_bmax, cfg_dmax;
  bit glitch_en;
  logic [31:0] start_log[$];
  logic [31:0] exp_ops[4];
  dump_t exp_q[$];
  dump_t mon_d;
  logic signed [ACC_W-1:0] ref_i = '0, ref_q = '0;
  int ref_cnt = 0, ref_len = 1;

  int m_wait, m_hi;
  bit m_active = 1'b0;
  logic signed [15:0] m_a, m_b;
  logic signed [31:0] m_prod;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Window model: each accepted pair adds its complex product; the window length is the
  // dump_len seen at the first pair of the window (0 meaning 1).
  task automatic ref_accept(input logic signed [15:0] xr, input logic signed [15:0] xi,
                            input logic signed [15:0] cr, input logic signed [15:0] ci,
                            input logic [CNT_W-1:0] len);
    longint pi, pq;
    if (ref_cnt == 0) ref_len = (len == '0) ? 1 : int'(len);
    pi = longint'(xr) * longint'(cr) - longint'(xi) * longint'(ci);
    pq = longint'(xr) * longint'(ci) + longint'(xi) * longint'(cr);
    ref_i = ref_i + pi[ACC_W-1:0];
    ref_q = ref_q + pq[ACC_W-1:0];
    ref_cnt++;
    n_accepted++;
    if (ref_cnt == ref_len) begin
      exp_q.push_back('{ref_i, ref_q, n_accepted});
      ref_i = '0;
      ref_q = '0;
      ref_cnt = 0;
    end
  endtask

  task automatic send(input logic signed [15:0] xr, input logic signed [15:0] xi,
                      input logic signed [15:0] cr, input logic signed [15:0] ci,
                      input int len, input bit keep);
    int guard;
    logic [CNT_W-1:0] lv;
    lv = len[CNT_W-1:0];
    @(negedge clk);
    bus.x_re = xr; bus.x_im = xi; bus.c_re = cr; bus.c_im = ci;
    bus.dump_len = lv;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check_val("accept_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    ref_accept(xr, xi, cr, ci, lv);
    #1;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_dumps(input int target, input int budget, output int cycles,
                            output int rdy_hi);
    cycles = 0;
    rdy_hi = 0;
    while (n_dumps < target && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
      if (bus.in_ready) rdy_hi++;
    end
    check_val("dump_wait", n_dumps, target);
  endtask

  // Multiplier model: busy rises after a random delay, stays high a random time, then the
  // product appears; mult_p carries junk while busy.
  always @(negedge clk) begin
    if (rst) begin
      bus.mult_busy = 1'b0;
      bus.mult_p    = 32'sd0;
      m_active      = 1'b0;
    end else if (bus.mult_start) begin
      n_starts++;
      start_log.push_back({bus.mult_a, bus.mult_b});
      m_a = bus.mult_a;
      m_b = bus.mult_b;
      m_prod = 32'(m_a) * 32'(m_b);
      m_wait = int'($urandom_range(cfg_dmax, 0));
      m_hi = int'($urandom_range(cfg_bmax, cfg_bmin));
      m_active = 1'b1;
      bus.mult_busy = 1'b0;
      bus.mult_p = $urandom;
    end else if (m_active) begin
      if (m_wait > 0) begin
        m_wait--;
      end else if (m_hi > 0) begin
        bus.mult_busy = 1'b1;
        m_hi--;
      end else begin
        check_val("op_hold", {bus.mult_a, bus.mult_b}, {m_a, m_b});
        bus.mult_busy = 1'b0;
        bus.mult_p = m_prod;
        m_active = 1'b0;
      end
    end else if (glitch_en && bus.in_ready && $urandom_range(3, 0) == 0) begin
      bus.mult_busy = 1'b1;
    end else begin
      bus.mult_busy = 1'b0;
    end
  end

  // Dump monitor against the reference queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      n_dumps++;
      check_val("dump_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_d = exp_q.pop_front();
        check_val("dump_i", bus.acc_i, mon_d.i);
        check_val("dump_q", bus.acc_q, mon_d.q);
        check_val("dump_at", n_accepted, mon_d.at);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, base, sbase, rdy_hi;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.x_re = 16'sd0; bus.x_im = 16'sd0; bus.c_re = 16'sd0; bus.c_im = 16'sd0;
    bus.dump_len = '0;
    cfg_bmin = 2; cfg_bmax = 2; cfg_dmax = 0; glitch_en = 1'b0;
    exp_ops[0] = {16'sd3, 16'sd2};
    exp_ops[1] = {16'sd4, 16'hFFFF};
    exp_ops[2] = {16'sd3, 16'hFFFF};
    exp_ops[3] = {16'sd4, 16'sd2};

    repeat (3) @(negedge clk);
    check_val("rst_in_ready", bus.in_ready, 0);
    check_val("rst_mult_start", bus.mult_start, 0);
    check_val("rst_mult_a", bus.mult_a, 0);
    check_val("rst_mult_b", bus.mult_b, 0);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_acc_i", bus.acc_i, 0);
    check_val("rst_acc_q", bus.acc_q, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rdy_after_rst", bus.in_ready, 1);

    // Basic product, operand order and per-sample latency with B=2.
    sbase = start_log.size();
    base = n_dumps;
    send(16'sd3, 16'sd4, 16'sd2, -16'sd1, 1, 1'b0);
    wait_dumps(base + 1, 200, cyc, rdy_hi);
    check_val("t1_latency", cyc, 18);
    check_val("t1_acc_i", bus.acc_i, 10);
    check_val("t1_acc_q", bus.acc_q, 5);
    check_val("t1_starts", start_log.size() - sbase, 4);
    for (int i = 0; i < 4 && sbase + i < start_log.size(); i++)
      check_val("t1_ops", start_log[sbase + i], exp_ops[i]);
    repeat (5) @(negedge clk);
    check_val("t1_hold_i", bus.acc_i, 10);
    check_val("t1_hold_q", bus.acc_q, 5);

    // Four-sample window with random multiplier latency.
    cfg_bmin = 1; cfg_bmax = 3; cfg_dmax = 1; glitch_en = 1'b1;
    base = n_dumps;
    for (int i = 0; i < 4; i++) send(16'sd1000, -16'sd2000, 16'sd1, 16'sd1, 4, 1'b0);
    check_val("t2_no_early", n_dumps, base);
    wait_dumps(base + 1, 300, cyc, rdy_hi);
    check_val("t2_acc_i", bus.acc_i, 12000);
    check_val("t2_acc_q", bus.acc_q, -64'sd4000);
    repeat (20) @(negedge clk);
    check_val("t2_one_dump", n_dumps, base + 1);

    // Operand extremes.
    base = n_dumps;
    send(-16'sd32768, -16'sd32768, -16'sd32768, 16'sd32767, 1, 1'b0);
    wait_dumps(base + 1, 300, cyc, rdy_hi);
    check_val("t3_acc_i", bus.acc_i, 64'sd2147450880);
    check_val("t3_acc_q", bus.acc_q, 32768);

    // Reset while waiting on the second multiply, then a clean sample.
    cfg_bmin = 3; cfg_bmax = 3; cfg_dmax = 0; glitch_en = 1'b0;
    sbase = n_starts;
    send(16'sd11, 16'sd22, 16'sd33, 16'sd44, 1, 1'b0);
    cyc = 0;
    while (!(n_starts == sbase + 2 && bus.mult_busy) && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_val("t4_reach_m1", n_starts - sbase, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check_val("t4_rst_start", bus.mult_start, 0);
    check_val("t4_rst_valid", bus.out_valid, 0);
    check_val("t4_rst_ready", bus.in_ready, 0);
    exp_q.delete();
    ref_i = '0; ref_q = '0; ref_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    base = n_dumps;
    send(16'sd5, 16'sd0, 16'sd7, 16'sd0, 1, 1'b0);
    wait_dumps(base + 1, 200, cyc, rdy_hi);
    check_val("t4_acc_i", bus.acc_i, 35);
    check_val("t4_acc_q", bus.acc_q, 0);

    // dump_len=0 with in_valid held across back-to-back samples.
    cfg_bmin = 2; cfg_bmax = 2;
    base = n_dumps;
    for (int i = 0; i < 3; i++) begin
      send(16'(i + 1), 16'sd0, 16'sd2, 16'sd0, 0, (i < 2));
      check_val("t5_rdy_drop", bus.in_ready, 0);
      wait_dumps(base + i + 1, 200, cyc, rdy_hi);
      check_val("t5_rdy_low", rdy_hi, 0);
      check_val("t5_acc_i", bus.acc_i, (i + 1) * 2);
    end

    // Random samples: first window 7 long, dump_len moved to 3 mid-window.
    cfg_bmin = 1; cfg_bmax = 3; cfg_dmax = 1; glitch_en = 1'b1;
    base = n_dumps;
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), (i < 3) ? 7 : 3, 1'b0);
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    cyc = 0;
    while (n_dumps < base + 332 && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_val("t6_dumps", n_dumps - base, 332);
    check_val("t6_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cplx_mac_seq.md
# cplx_mac_seq

Complex multiply-accumulate sequencer for the correlator datapath. It accepts one complex sample and one complex replica per transaction. Each complex product is computed as four signed 16x16 real multiplies on a single shared `mult_16x16` instance, driven over its start/busy handshake. It accumulates the in-phase and quadrature results over a programmable window, then dumps them to the tracking loop.

## Interface
Parameters:
- `ACC_W`, 48: accumulator and output width, two's complement.
- `CNT_W`, 16: width of the window-length and sample counters.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  sample/replica pair offered.
- `in_ready`  out  1  block can accept a pair this cycle.
- `x_re`, `x_im`  in  16 each  signed sample.
- `c_re`, `c_im`  in  16 each  signed replica.
- `dump_len`  in  CNT_W  samples per window; a value of 0 is treated as 1.
- `mult_a`, `mult_b`  out  16 each  operands to the multiplier.
- `mult_start`  out  1  one-cycle start pulse to the multiplier.
- `mult_busy`  in  1  multiplier busy.
- `mult_p`  in  32  signed multiplier product.
- `out_valid`  out  1  one-cycle dump strobe.
- `acc_i`, `acc_q`  out  ACC_W each  dumped window sums.

## Operation
- Computes I = xr·cr − xi·ci and Q = xr·ci + xi·cr.
- Multiply order is fixed: M0 = xr·cr, M1 = xi·ci, M2 = xr·ci, M3 = xi·cr.
- States:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch x, c, and the window length (if this is the first sample of a window), then go to START with k=0.
  - START: `mult_start`=1 for exactly one cycle, with `mult_a`/`mult_b` = operands of Mk. Go to WAIT_HI.
  - WAIT_HI: wait for `mult_busy`=1.
  - WAIT_LO: wait for `mult_busy`=0. In the first cycle with busy low, capture `mult_p`, sign-extend it to ACC_W, and accumulate:
    - M0 adds to I, M1 subtracts from I.
    - M2 and M3 add to Q.
  - After capture: if k<3, k++ and go to START. Otherwise go to NEXT.
  - NEXT: increment the sample counter. If the counter reaches the latched length, go to DUMP; otherwise go to IDLE.
  - DUMP: register `acc_i`/`acc_q`, pulse `out_valid`, clear the accumulators and the sample counter, then go to IDLE.
- `mult_a`/`mult_b` are held stable from START through the capture cycle.
- `dump_len` is sampled only at the first sample of a window. Mid-window changes take effect at the next window.
- Accumulators wrap modulo 2^ACC_W. There is no saturation and no overflow flag.
- `acc_i`/`acc_q` hold their last dumped value until the next DUMP.
- `mult_start` is never asserted outside START.

## Timing
- Reset values: state IDLE, `in_ready`=0, `mult_start`=0, `mult_a`=`mult_b`=0, `out_valid`=0, `acc_i`=`acc_q`=0, accumulators=0, counter=0. `in_ready` is registered and rises on the first clock edge after `rst` deasserts.
- Latency per multiply:
  - 1 START cycle,
  - plus cycles until busy rises,
  - plus the busy-high duration B,
  - plus 1 capture cycle.
- Per sample, including the NEXT cycle: 4·(B+2)+1 cycles minimum when busy rises the cycle after start.
- `out_valid` fires one cycle after the NEXT cycle of the last sample in the window.
- `in_ready` drops in the cycle after acceptance and reasserts on return to IDLE. There is no input buffering.
- Reset asserted mid-operation: immediately abandon the sample, drop `mult_start`, return to IDLE, and discard partial accumulation. The multiplier shares the same reset source.
- `mult_busy` glitches (high while in IDLE) are ignored.

## Test plan
- `dump_len`=1, x=(3,4), c=(2,−1) -> one `out_valid`, `acc_i`=10, `acc_q`=5, and exactly 4 `mult_start` pulses with operands in order (3,2), (4,−1), (3,−1), (4,2).
- `dump_len`=4, four samples x=(1000,−2000), c=(1,1) -> one `out_valid` after the 4th sample only, `acc_i`=12000, `acc_q`=−4000.
- Extremes: `dump_len`=1, x=(−32768,−32768), c=(−32768,32767) -> `acc_i`=2147450880, `acc_q`=32768.
- Reset during WAIT_LO of M1 -> during reset, `mult_start`=0, `out_valid`=0, `in_ready`=0. After release, with `dump_len`=1, x=(5,0), c=(7,0) -> `acc_i`=35, `acc_q`=0 (no residue).
- `dump_len`=0 with `in_valid` held high for 3 back-to-back samples -> `out_valid` after each sample, and `in_ready` low from the acceptance cycle until IDLE.
- `dump_len`=7 changed to 3 mid-window, 1000 random samples -> first window dumps after 7 samples, later windows after 3; sums match the golden model.
